// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared widths, FSM state type and helpers
// for the TX byte reader slice.
package eth_tx_pkg;

  localparam int ADDR_W = 9;
  localparam int LEN_W  = 11;
  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Number of 64-bit words covering n bytes.
  function automatic logic [ADDR_W:0] word_count(
    input logic [LEN_W-1:0] n
  );
    logic [LEN_W:0] t;
    t = {1'b0, n} + (LEN_W+1)'(7);
    return (ADDR_W+1)'(t >> 3);
  endfunction

endpackage

// File: rtl/eth_tx_word_fifo.sv
// eth_tx_word_fifo: 2-entry 64-bit synchronous FIFO
// holding fetched frame words ahead of the byte mux.
module eth_tx_word_fifo
  import eth_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] wdata,
  input  logic              pop,
  output logic [WORD_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [1:0]        level
);

  logic [WORD_W-1:0] mem0;
  logic [WORD_W-1:0] mem1;
  logic              wptr;
  logic              rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == 2'd2);
  assign empty   = (level == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = rptr ? mem1 : mem0;

  // Storage, pointers and occupancy; reset flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem0  <= '0;
      mem1  <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      level <= 2'd0;
    end else begin
      if (do_push) begin
        if (wptr) mem1 <= wdata;
        else      mem0 <= wdata;
        wptr <= ~wptr;
      end
      if (do_pop) rptr <= ~rptr;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/eth_tx_byte_reader.sv
// eth_tx_byte_reader: fetches a frame as 64-bit words and
// streams it LSB byte first toward the TX MAC.
module eth_tx_byte_reader
  import eth_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  output logic              tx_last_o,
  input  logic              tx_ready_i
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  sent;
  logic [ADDR_W:0]   fetched;
  logic [ADDR_W:0]   words;
  logic              inflight;

  logic              accept;
  logic              fetch;
  logic              valid;
  logic              fire;
  logic              is_last;
  logic              pop;
  logic [1:0]        pend;

  logic [WORD_W-1:0] head;
  logic              full;
  logic              empty;
  logic [1:0]        level;

  eth_tx_word_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .wdata (mem_rdata_i),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Reads in flight still need a slot, so count them.
  assign pend    = level + {1'b0, inflight};
  assign accept  = start_i && (len_i != '0) && (state != RUN);
  assign fetch   = (state == RUN) && (fetched != words)
                && !full && (pend < 2'd2);
  assign valid   = (state == RUN) && !empty;
  assign fire    = valid && tx_ready_i;
  assign is_last = (sent == (len - LEN_W'(1)));
  assign pop     = fire && (is_last || (sent[2:0] == 3'd7));

  assign busy_o     = (state == RUN);
  assign done_o     = (state == DONE);
  assign mem_en_o   = fetch;
  assign mem_addr_o = addr;
  assign tx_valid_o = valid;
  assign tx_last_o  = valid && is_last;
  assign tx_data_o  = valid ? head[{sent[2:0], 3'b000} +: 8] : 8'h00;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (fire && is_last) state_nx = DONE;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command latch, fetch address/counter and byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      len      <= '0;
      sent     <= '0;
      fetched  <= '0;
      words    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fetch;
      if (accept) begin
        addr    <= base_i;
        len     <= len_i;
        sent    <= '0;
        fetched <= '0;
        words   <= word_count(len_i);
      end else begin
        if (fetch) begin
          addr    <= addr + ADDR_W'(1);
          fetched <= fetched + (ADDR_W+1)'(1);
        end
        if (fire) sent <= sent + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_byte_reader.sv
// tb_eth_tx_byte_reader: scoreboard bench for the TX byte
// reader with a 1-cycle-latency frame buffer model.
module tb_eth_tx_byte_reader;
  import eth_tx_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] base_i = '0;
  logic [LEN_W-1:0]  len_i = '0;
  logic              busy_o;
  logic              done_o;
  logic              mem_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [WORD_W-1:0] mem_rdata_i = '0;
  logic [7:0]        tx_data_o;
  logic              tx_valid_o;
  logic              tx_last_o;
  logic              tx_ready_i = 1'b1;

  logic [WORD_W-1:0] mem [512];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  int   first_q[$];
  int   last_q[$];
  int   done_q[$];
  int   frame_pos = 0;
  int   reads = 0;
  int   issued = 0;
  int   consumed = 0;
  int   max_occ = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic stall = 1'b0;
  logic [7:0] hold_data = '0;
  logic hold_last = 1'b0;

  eth_tx_byte_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_i      (base_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem_en_o    (mem_en_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_last_o   (tx_last_o),
    .tx_ready_i  (tx_ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (mem_en_o) mem_rdata_i <= mem[mem_addr_o];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Monitor: sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      frame_pos = 0;
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", 64'(tx_valid_o), 64'd1);
        check("hold_data", 64'(tx_data_o), 64'(hold_data));
        check("hold_last", 64'(tx_last_o), 64'(hold_last));
      end
      if (mem_en_o) begin
        check("rd_addr", 64'(mem_addr_o), 64'(exp_addr));
        exp_addr = exp_addr + 9'd1;
        reads++;
        issued++;
      end
      if (issued - consumed > max_occ) max_occ = issued - consumed;
      if (done_o) done_q.push_back(cyc);
      if (tx_valid_o && tx_ready_i) begin
        if (exp_q.size() == 0) begin
          check("spurious_byte", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 64'(tx_data_o), 64'(e.d));
          check("tx_last", 64'(tx_last_o), 64'(e.l));
        end
        if (frame_pos == 0) first_q.push_back(cyc);
        if (tx_last_o) begin
          last_q.push_back(cyc);
          consumed++;
          frame_pos = 0;
        end else begin
          if (frame_pos % 8 == 7) consumed++;
          frame_pos++;
        end
      end
      stall = tx_valid_o && !tx_ready_i;
      hold_data = tx_data_o;
      hold_last = tx_last_o;
    end
  end

  task automatic load(input logic [ADDR_W-1:0] base,
                      input int len, input bit seq);
    int nw;
    logic [63:0] w;
    logic [ADDR_W-1:0] a;
    exp_t e;
    nw = (len + 7) / 8;
    for (int i = 0; i < nw; i++) begin
      for (int k = 0; k < 8; k++)
        w[8*k +: 8] = seq ? 8'(i * 8 + k) : 8'($urandom);
      a = base + 9'(i);
      mem[a] = w;
    end
    for (int i = 0; i < len; i++) begin
      a = base + 9'(i / 8);
      w = mem[a];
      e.d = w[8*(i % 8) +: 8];
      e.l = (i == len - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic kick(input logic [ADDR_W-1:0] base,
                      input int len, output int t0);
    exp_addr = base;
    reads = 0;
    max_occ = 0;
    start_i = 1'b1;
    base_i = base;
    len_i = 11'(len);
    t0 = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit rnd);
    int n;
    n = 0;
    while (done_q.size() == 0 && n < limit) begin
      @(posedge clk); #1;
      if (rnd) tx_ready_i = 1'($urandom_range(0, 1));
      n++;
    end
    if (done_q.size() == 0) check("done_timeout", 64'd0, 64'd1);
    tx_ready_i = 1'b1;
  endtask

  task automatic finish_frame(input int t0, input int len,
                              input bit timed, input int nreads);
    int f, l, d;
    if (first_q.size() == 0 || last_q.size() == 0
        || done_q.size() == 0) begin
      check("frame_events", 64'd0, 64'd1);
      return;
    end
    f = first_q.pop_front();
    l = last_q.pop_front();
    d = done_q.pop_front();
    if (timed) begin
      check("first_cycle", 64'(f - t0), 64'd3);
      check("last_cycle", 64'(l - t0), 64'(len + 2));
      check("done_cycle", 64'(d - t0), 64'(len + 3));
    end else begin
      check("done_after_last", 64'(d - l), 64'd1);
    end
    if (nreads >= 0) check("reads", 64'(reads), 64'(nreads));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_mem_en"}, 64'(mem_en_o), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr_o), 64'd0);
    check({tag, "_valid"}, 64'(tx_valid_o), 64'd0);
    check({tag, "_last"}, 64'(tx_last_o), 64'd0);
    check({tag, "_data"}, 64'(tx_data_o), 64'd0);
  endtask

  initial begin
    int t0, t1, n;

    for (int i = 0; i < 512; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Sequential 16-byte frame, cycle-exact.
    load(9'h010, 16, 1'b1);
    kick(9'h010, 16, t0);
    @(negedge clk);
    check("c1_busy", 64'(busy_o), 64'd1);
    check("c1_mem_en", 64'(mem_en_o), 64'd1);
    @(posedge clk); #1;
    wait_done(400, 1'b0);
    finish_frame(t0, 16, 1'b1, 2);
    check("q_empty_16", 64'(exp_q.size()), 64'd0);

    // Partial final word.
    load(9'h020, 13, 1'b0);
    kick(9'h020, 13, t0);
    wait_done(400, 1'b0);
    finish_frame(t0, 13, 1'b1, 2);

    // Address wrap 0x1FF -> 0x000.
    load(9'h1FF, 9, 1'b0);
    kick(9'h1FF, 9, t0);
    wait_done(400, 1'b0);
    finish_frame(t0, 9, 1'b1, 2);
    check("wrap_next_addr", 64'(exp_addr), 64'd1);

    // Random backpressure.
    load(9'h0A0, 100, 1'b0);
    kick(9'h0A0, 100, t0);
    wait_done(3000, 1'b1);
    finish_frame(t0, 100, 1'b0, 13);
    check("occupancy_le3", 64'(max_occ <= 3), 64'd1);
    check("q_empty_100", 64'(exp_q.size()), 64'd0);

    // Zero-length start is ignored.
    reads = 0;
    start_i = 1'b1;
    base_i = 9'h055;
    len_i = '0;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("len0_busy", 64'(busy_o), 64'd0);
      check("len0_mem_en", 64'(mem_en_o), 64'd0);
    end
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    check("len0_done", 64'(done_q.size()), 64'd0);
    check("len0_reads", 64'(reads), 64'd0);

    // Start while busy is ignored.
    load(9'h040, 20, 1'b0);
    kick(9'h040, 20, t0);
    repeat (3) begin @(posedge clk); #1; end
    start_i = 1'b1;
    base_i = 9'h100;
    len_i = 11'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(400, 1'b0);
    finish_frame(t0, 20, 1'b1, 3);
    repeat (3) begin @(posedge clk); #1; end
    check("busy_ign_idle", 64'(busy_o), 64'd0);
    check("busy_ign_done", 64'(done_q.size()), 64'd0);
    check("busy_ign_q", 64'(exp_q.size()), 64'd0);

    // Start in the DONE cycle.
    load(9'h080, 8, 1'b0);
    load(9'h090, 10, 1'b0);
    kick(9'h080, 8, t0);
    while (cyc < t0 + 11) begin @(posedge clk); #1; end
    kick(9'h090, 10, t1);
    finish_frame(t0, 8, 1'b1, -1);
    wait_done(400, 1'b0);
    finish_frame(t1, 10, 1'b1, 2);
    check("b2b_q", 64'(exp_q.size()), 64'd0);

    // Reset while byte 5 is on the stream.
    load(9'h020, 40, 1'b0);
    kick(9'h020, 40, t0);
    n = 0;
    while (frame_pos != 5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_byte5", 64'(frame_pos), 64'd5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("no_done_rst", 64'(done_q.size()), 64'd0);
    check("idle_after_rst", 64'(busy_o), 64'd0);
    exp_q.delete();
    first_q.delete();
    last_q.delete();
    done_q.delete();
    issued = 0;
    consumed = 0;
    load(9'h030, 12, 1'b0);
    kick(9'h030, 12, t0);
    wait_done(400, 1'b0);
    finish_frame(t0, 12, 1'b1, 2);
    check("post_rst_q", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
